// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// an elaboration-time clog2 used to size bit counters.
package arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half-adder stages and an OR; the single
// arithmetic cell of the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic p1, g1, g2;

  assign p1   = A ^ B;
  assign g1   = A & B;
  assign Sum  = p1 ^ Cin;
  assign g2   = p1 & Cin;
  assign Cout = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes operands LSB first,
// with a start/busy/done handshake and registered parallel result.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .A   (a_sh_q[0]),
    .B   (b_sh_q[0]),
    .Cin (c_q),
    .Sum (fa_s),
    .Cout(fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      s_sh_q <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      s_sh_q <= s_sh_d;
      sum_q  <= sum_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          c_d     = Cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_c;
        cnt_d  = cnt_q + CW'(1);
        // The last bit goes straight into the result register, bypassing the shifter.
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Cin = 1'b0;
  logic       busy, done, Cout;
  logic [7:0] Sum;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one operation and wait (bounded) for done; returns result, edges
  // from accept to done, and number of sampled cycles with busy high.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       output logic [8:0] res, output int lat, output int bc);
    @(negedge clk);
    A = a; B = b; Cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
    res = {Cout, Sum};
  endtask

  logic [8:0] res;
  logic [7:0] s_cap;
  int lat, bc, nd;

  initial begin
    #1;
    chk("reset_sum", Sum, 8'h00);
    chk("reset_cout", Cout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Carry ripple through all bits
    do_op(8'hFF, 8'h01, 1'b0, res, lat, bc);
    chk("ripple_res", res, 9'h100);
    chk("ripple_lat", lat, 8);
    chk("ripple_busy_cycles", bc, 8);
    chk("ripple_busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("ripple_done_pulse", done, 0);
    chk("ripple_hold", {Cout, Sum}, 9'h100);

    do_op(8'h5A, 8'hA5, 1'b1, res, lat, bc);
    chk("cin_res", res, 9'h100);
    do_op(8'h37, 8'h29, 1'b0, res, lat, bc);
    chk("plain_res", res, 9'h060);
    chk("plain_lat", lat, 8);
    @(posedge clk); #1;

    // Start pulse and operand change mid-RUN must be ignored
    @(negedge clk);
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; s_cap = 8'hEE;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) begin nd++; s_cap = Sum; end
    end
    chk("ignore_start_sum", s_cap, 8'h30);
    chk("ignore_start_ndone", nd, 1);

    // Asynchronous reset in the middle of a computation
    @(negedge clk);
    A = 8'hC3; B = 8'h3C; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_sum", Sum, 8'h00);
    chk("rst_mid_cout", Cout, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("rst_mid_no_done", nd, 0);
    do_op(8'h03, 8'h04, 1'b0, res, lat, bc);
    chk("after_rst_res", res, 9'h007);
    @(posedge clk); #1;

    // Back-to-back chaining through the DONE cycle
    do_op(8'h12, 8'h34, 1'b0, res, lat, bc);
    chk("b2b_first_res", res, 9'h046);
    chk("b2b_first_done", done, 1);
    @(negedge clk);
    A = 8'h80; B = 8'h80; Cin = 1'b0; start = 1'b1;
    #1;
    chk("b2b_hold_in_done", {Cout, Sum}, 9'h046);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rerun_busy", busy, 1);
    chk("b2b_rerun_done", done, 0);
    chk("b2b_hold_in_run", {Cout, Sum}, 9'h046);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_second_lat", lat, 8);
    chk("b2b_second_res", {Cout, Sum}, 9'h100);
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] exp9;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      do_op(ra, rb, rc, res, lat, bc);
      chk("rand_res", res, exp9);
      chk("rand_lat", lat, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
